// File: rtl/dpram_be_pipe.sv
// True dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// deterministic read/write collision handling and a built-in clear engine.
module dpram_be_pipe #(
    parameter int RAM_SIZE       = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  rd_a,
    input  logic                  wr_a,
    input  logic [NB-1:0]         be_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  rvalid_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  rd_b,
    input  logic                  wr_b,
    input  logic [NB-1:0]         be_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid_b,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  wr_coll
);
    localparam int                  IDX_W    = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_X   = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    // Port A lanes take priority; a lane falls back to port B only when A leaves it alone.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] wd_a,
        input logic [NB-1:0]         en_a,
        input logic [DATA_WIDTH-1:0] wd_b,
        input logic [NB-1:0]         en_b
    );
        logic [DATA_WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < NB; i++) begin
            if (en_a[i])
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = wd_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (en_b[i])
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = wd_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    state_t                state;
    logic [IDX_W-1:0]      clr_cnt;
    logic                  active;
    logic                  in_a, in_b, wa, wb, same, coll;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, rword_a, rword_b;

    logic [DATA_WIDTH-1:0] rdata_a_p0, rdata_b_p0;
    logic                  vld_a_p0, vld_b_p0, coll_p0;

    // mrg_x is the post-write value of addr_x with both ports' lanes applied,
    // so it doubles as the write-back word and the read-new-data word.
    always_comb begin
        active  = (state == IDLE);
        in_a    = {1'b0, addr_a} < SIZE_X;
        in_b    = {1'b0, addr_b} < SIZE_X;
        idx_a   = addr_a[IDX_W-1:0];
        idx_b   = addr_b[IDX_W-1:0];
        wa      = active && wr_a && in_a;
        wb      = active && wr_b && in_b;
        same    = (addr_a == addr_b);
        old_a   = in_a ? mem[idx_a] : '0;
        old_b   = in_b ? mem[idx_b] : '0;
        mrg_a   = merge_lanes(old_a, wdata_a, wa ? be_a : '0,
                              wdata_b, (wb && same) ? be_b : '0);
        mrg_b   = merge_lanes(old_b, wdata_a, (wa && same) ? be_a : '0,
                              wdata_b, wb ? be_b : '0);
        rword_a = (RDW_MODE != 0) ? old_a : mrg_a;
        rword_b = (RDW_MODE != 0) ? old_b : mrg_b;
        coll    = wa && wb && same && ((be_a & be_b) != '0);
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wa)
                mem[idx_a] <= mrg_a;
            if (wb && !(wa && same))
                mem[idx_b] <= mrg_b;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            busy    <= (CLEAR_ON_RESET != 0);
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0: array read register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata_a_p0 <= '0;
            rdata_b_p0 <= '0;
            vld_a_p0   <= 1'b0;
            vld_b_p0   <= 1'b0;
            coll_p0    <= 1'b0;
        end else begin
            vld_a_p0 <= active && rd_a;
            vld_b_p0 <= active && rd_b;
            coll_p0  <= coll;
            if (active && rd_a)
                rdata_a_p0 <= rword_a;
            if (active && rd_b)
                rdata_b_p0 <= rword_b;
        end
    end

    assign wr_coll = coll_p0;

    // Stage 1: optional output register
    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] rdata_a_p1, rdata_b_p1;
        logic                  vld_a_p1, vld_b_p1;

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                rdata_a_p1 <= '0;
                rdata_b_p1 <= '0;
                vld_a_p1   <= 1'b0;
                vld_b_p1   <= 1'b0;
            end else begin
                vld_a_p1 <= vld_a_p0;
                vld_b_p1 <= vld_b_p0;
                if (vld_a_p0)
                    rdata_a_p1 <= rdata_a_p0;
                if (vld_b_p0)
                    rdata_b_p1 <= rdata_b_p0;
            end
        end

        assign rdata_a  = rdata_a_p1;
        assign rdata_b  = rdata_b_p1;
        assign rvalid_a = vld_a_p1;
        assign rvalid_b = vld_b_p1;
    end else begin : g_noreg
        assign rdata_a  = rdata_a_p0;
        assign rdata_b  = rdata_b_p0;
        assign rvalid_a = vld_a_p0;
        assign rvalid_b = vld_b_p0;
    end

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Bench for dpram_be_pipe: two instances (1-cycle/new-data and 2-cycle/old-data)
// share one stimulus stream and are checked against a word-array reference model.
module tb_dpram_be_pipe;
    localparam int RS = 16;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          rd_a, wr_a, rd_b, wr_b, clear_req;
    logic [NB-1:0] be_a, be_b;
    logic [DW-1:0] wdata_a, wdata_b;

    logic [DW-1:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic          rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic          busy0, busy1, wr_coll0, wr_coll1;

    always #5 clk = ~clk;

    dpram_be_pipe #(.RAM_SIZE(RS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_b(rst_b),
        .addr_a(addr_a), .rd_a(rd_a), .wr_a(wr_a), .be_a(be_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .addr_b(addr_b), .rd_b(rd_b), .wr_b(wr_b), .be_b(be_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .clear_req(clear_req), .busy(busy0), .wr_coll(wr_coll0));

    dpram_be_pipe #(.RAM_SIZE(RS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                    .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_b(rst_b),
        .addr_a(addr_a), .rd_a(rd_a), .wr_a(wr_a), .be_a(be_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .addr_b(addr_b), .rd_b(rd_b), .wr_b(wr_b), .be_b(be_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .clear_req(clear_req), .busy(busy1), .wr_coll(wr_coll1));

    int total = 0;
    int bad   = 0;

    // Reference model state: array contents, clear progress, expected outputs.
    logic [DW-1:0] mm [RS];
    bit            busy_m;
    int            ccnt;
    bit            coll_m;
    bit            e0va, e0vb, e1va, e1vb, p1va, p1vb;
    logic [DW-1:0] e0da, e0db, e1da, e1db, p1da, p1db;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
        if (int'(a) < RS) return mm[a[3:0]];
        return '0;
    endfunction

    task automatic mwr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        if (int'(a) < RS)
            for (int i = 0; i < NB; i++)
                if (be[i]) mm[a[3:0]][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic model_reset();
        busy_m = 1'b1; ccnt = 0; coll_m = 1'b0;
        e0va = 0; e0vb = 0; e1va = 0; e1vb = 0; p1va = 0; p1vb = 0;
        e0da = '0; e0db = '0; e1da = '0; e1db = '0; p1da = '0; p1db = '0;
    endtask

    task automatic check_all();
        chk1("busy0", busy0, busy_m);
        chk1("busy1", busy1, busy_m);
        chk1("wr_coll0", wr_coll0, coll_m);
        chk1("wr_coll1", wr_coll1, coll_m);
        chk1("rvalid_a0", rvalid_a0, e0va);
        chk1("rvalid_b0", rvalid_b0, e0vb);
        chk1("rvalid_a1", rvalid_a1, e1va);
        chk1("rvalid_b1", rvalid_b1, e1vb);
        chk32("rdata_a0", rdata_a0, e0da);
        chk32("rdata_b0", rdata_b0, e0db);
        chk32("rdata_a1", rdata_a1, e1da);
        chk32("rdata_b1", rdata_b1, e1db);
    endtask

    // One clock: advance the model using the current inputs, then compare.
    task automatic tick();
        bit            ra, rb, cl;
        logic [DW-1:0] oa, ob, na, nb;
        ra = 0; rb = 0; cl = 0; oa = '0; ob = '0; na = '0; nb = '0;
        if (busy_m) begin
            mm[ccnt] = '0;
            if (ccnt == RS - 1) busy_m = 1'b0;
            ccnt++;
        end else begin
            if (clear_req) begin
                busy_m = 1'b1;
                ccnt   = 0;
            end
            ra = rd_a;
            rb = rd_b;
            oa = mrd(addr_a);
            ob = mrd(addr_b);
            if (wr_b) mwr(addr_b, be_b, wdata_b);
            if (wr_a) mwr(addr_a, be_a, wdata_a);
            na = mrd(addr_a);
            nb = mrd(addr_b);
            cl = wr_a && wr_b && (addr_a == addr_b) && (int'(addr_a) < RS) && ((be_a & be_b) != '0);
        end
        coll_m = cl;
        e1va = p1va; if (p1va) e1da = p1da;
        e1vb = p1vb; if (p1vb) e1db = p1db;
        p1va = ra;   if (ra) p1da = oa;
        p1vb = rb;   if (rb) p1db = ob;
        e0va = ra;   if (ra) e0da = na;
        e0vb = rb;   if (rb) e0db = nb;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0; clear_req = 0;
        addr_a = '0; addr_b = '0; be_a = '0; be_b = '0; wdata_a = '0; wdata_b = '0;
    endtask

    task automatic rand_inputs(input bit allow_clear);
        rd_a    = 1'($urandom_range(0, 1));
        wr_a    = 1'($urandom_range(0, 1));
        rd_b    = 1'($urandom_range(0, 1));
        wr_b    = 1'($urandom_range(0, 1));
        addr_a  = AW'($urandom_range(0, 19));
        addr_b  = ($urandom_range(0, 1) == 1) ? addr_a : AW'($urandom_range(0, 19));
        be_a    = NB'($urandom);
        be_b    = NB'($urandom);
        wdata_a = $urandom;
        wdata_b = $urandom;
        clear_req = allow_clear && ($urandom_range(0, 63) == 0);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk32(nm, n, RS);
    endtask

    typedef struct {
        bit            same;
        logic [AW-1:0] a_ad;
        logic [NB-1:0] a_be;
        logic [DW-1:0] a_d;
        bit            b_wr;
        logic [AW-1:0] b_ad;
        logic [NB-1:0] b_be;
        logic [DW-1:0] b_d;
        logic [AW-1:0] r_ad;
        logic [DW-1:0] exp_d;
        bit            exp_coll;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 5'd3,  4'b1111, 32'hAABBCCDD, 1, 5'd3,  4'b0101, 32'h11223344, 5'd3,  32'hAA22CC44, 0};
        vt[1] = '{0, 5'd7,  4'b1000, 32'h9A000000, 0, 5'd0,  4'b0000, 32'h0,        5'd7,  32'h9A000000, 0};
        vt[2] = '{1, 5'd7,  4'b0011, 32'h12345678, 1, 5'd7,  4'b0110, 32'h9ABCDEF0, 5'd7,  32'h9ABC5678, 1};
        vt[3] = '{1, 5'd4,  4'b0001, 32'h000000AA, 1, 5'd4,  4'b0001, 32'h000000BB, 5'd4,  32'h000000AA, 1};
        vt[4] = '{1, 5'd10, 4'b0011, 32'h00001111, 1, 5'd11, 4'b1100, 32'h22220000, 5'd11, 32'h22220000, 0};
        vt[5] = '{0, 5'd20, 4'b1111, 32'hDEADBEEF, 0, 5'd0,  4'b0000, 32'h0,        5'd20, 32'h00000000, 0};
        vt[6] = '{0, 5'd12, 4'b0000, 32'hFFFFFFFF, 0, 5'd0,  4'b0000, 32'h0,        5'd12, 32'h00000000, 0};

        set_idle();
        rst_b = 1'b1;
        model_reset();
        #2 rst_b = 1'b0;
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        rst_b = 1'b1;
        count_busy("clear_len_por");

        set_idle(); rd_a = 1; addr_a = 5'd5;
        tick();
        set_idle();
        chk1("rd5_rvalid_a0", rvalid_a0, 1'b1);
        chk32("rd5_rdata_a0", rdata_a0, 32'h0);
        chk1("rd5_rvalid_a1_early", rvalid_a1, 1'b0);
        tick();
        chk1("rd5_rvalid_a0_pulse", rvalid_a0, 1'b0);
        chk1("rd5_rvalid_a1", rvalid_a1, 1'b1);

        foreach (vt[i]) begin
            set_idle();
            wr_a = 1; addr_a = vt[i].a_ad; be_a = vt[i].a_be; wdata_a = vt[i].a_d;
            if (vt[i].same && vt[i].b_wr) begin
                wr_b = 1; addr_b = vt[i].b_ad; be_b = vt[i].b_be; wdata_b = vt[i].b_d;
            end
            tick();
            if (!vt[i].same && vt[i].b_wr) begin
                set_idle();
                wr_b = 1; addr_b = vt[i].b_ad; be_b = vt[i].b_be; wdata_b = vt[i].b_d;
                tick();
            end
            chk1($sformatf("vec%0d_coll0", i), wr_coll0, vt[i].exp_coll);
            chk1($sformatf("vec%0d_coll1", i), wr_coll1, vt[i].exp_coll);
            set_idle(); rd_a = 1; addr_a = vt[i].r_ad;
            tick();
            set_idle();
            chk32($sformatf("vec%0d_rdata0", i), rdata_a0, vt[i].exp_d);
            chk1($sformatf("vec%0d_rvalid0", i), rvalid_a0, 1'b1);
            tick();
            chk32($sformatf("vec%0d_rdata1", i), rdata_a1, vt[i].exp_d);
            chk1($sformatf("vec%0d_rvalid1", i), rvalid_a1, 1'b1);
        end

        // Read-during-write across ports and on the same port.
        set_idle();
        wr_a = 1; addr_a = 5'd9; be_a = 4'hF; wdata_a = 32'hFFFFFFFF;
        rd_b = 1; addr_b = 5'd9;
        tick();
        set_idle();
        chk32("rdw_xport_new", rdata_b0, 32'hFFFFFFFF);
        tick();
        chk32("rdw_xport_old", rdata_b1, 32'h00000000);
        set_idle();
        rd_a = 1; wr_a = 1; addr_a = 5'd13; be_a = 4'b0011; wdata_a = 32'h1234ABCD;
        tick();
        set_idle();
        chk32("rdw_self_new", rdata_a0, 32'h0000ABCD);
        tick();
        chk32("rdw_self_old", rdata_a1, 32'h00000000);

        // Clear under traffic, with a second clear_req pulsed mid-clear.
        set_idle(); clear_req = 1;
        tick();
        begin
            int n;
            n = 0;
            while (busy0 === 1'b1 && n < 40) begin
                rand_inputs(0);
                if (n == 5) clear_req = 1;
                tick();
                n++;
            end
            chk32("clear_len_traffic", n, RS);
        end

        // Fill, then reset partway through a clear.
        for (int i = 0; i < RS; i++) begin
            set_idle(); wr_a = 1; addr_a = AW'(i); be_a = 4'hF; wdata_a = $urandom | 32'h1;
            tick();
        end
        set_idle(); rd_b = 1; addr_b = 5'd15;
        tick();
        set_idle(); clear_req = 1;
        tick();
        set_idle();
        for (int i = 0; i < 8; i++) tick();
        rst_b = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        rst_b = 1'b1;
        count_busy("clear_len_rst");
        for (int i = 0; i < RS; i++) begin
            set_idle(); rd_a = 1; addr_a = AW'(i);
            tick();
            chk32($sformatf("postclr_rd%0d", i), rdata_a0, 32'h0);
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rand_inputs(1);
            tick();
        end
        set_idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
